wb_cmd_master: RTL and testbench

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

---
 rtl/wb_cmd_master_if.sv | 43 ++++
 rtl/wb_cmd_master.sv | 99 +++++++++
 tb/tb_wb_cmd_master.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/wb_cmd_master_if.sv
// Command/response handshake plus Wishbone classic master bus, bundled for wb_cmd_master.
// The master modport is the bridge's view; slave is the requester/bus-slave side.
interface wb_cmd_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SEL = DW / 8;

  logic           cmd_valid_i;
  logic           cmd_ready_o;
  logic           cmd_we_i;
  logic [AW-1:0]  cmd_adr_i;
  logic [DW-1:0]  cmd_dat_i;
  logic [SEL-1:0] cmd_sel_i;

  logic           rsp_valid_o;
  logic           rsp_ready_i;
  logic [DW-1:0]  rsp_dat_o;
  logic           rsp_err_o;

  logic           wbm_cyc_o;
  logic           wbm_stb_o;
  logic           wbm_we_o;
  logic [AW-1:0]  wbm_adr_o;
  logic [DW-1:0]  wbm_dat_o;
  logic [SEL-1:0] wbm_sel_o;
  logic [DW-1:0]  wbm_dat_i;
  logic           wbm_ack_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  rsp_ready_i, wbm_dat_i, wbm_ack_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output rsp_ready_i, wbm_dat_i, wbm_ack_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Single-outstanding command to Wishbone classic bridge with ack timeout.
// One bus cycle per accepted command; response held until consumed.
module wb_cmd_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_cmd_master_if.master    bus
);
  localparam int SEL = DW / 8;
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t         state_reg;
  logic [7:0]     cnt_reg;
  logic           rdy_reg;
  logic           cyc_reg;
  logic           we_reg;
  logic [AW-1:0]  adr_reg;
  logic [DW-1:0]  dat_reg;
  logic [SEL-1:0] sel_reg;
  logic           rsp_valid_reg;
  logic           rsp_err_reg;
  logic [DW-1:0]  rsp_dat_reg;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rdy_reg       <= 1'b0;
      cyc_reg       <= 1'b0;
      we_reg        <= 1'b0;
      adr_reg       <= '0;
      dat_reg       <= '0;
      sel_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_dat_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Ready rises one edge after entering IDLE, so acceptance waits for it.
          rdy_reg <= 1'b1;
          if (rdy_reg && bus.cmd_valid_i) begin
            rdy_reg   <= 1'b0;
            we_reg    <= bus.cmd_we_i;
            adr_reg   <= bus.cmd_adr_i;
            dat_reg   <= bus.cmd_dat_i;
            sel_reg   <= bus.cmd_sel_i;
            cyc_reg   <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= BUS;
          end
        end
        BUS: begin
          if (bus.wbm_ack_i) begin
            cyc_reg       <= 1'b0;
            rsp_dat_reg   <= we_reg ? '0 : bus.wbm_dat_i;
            rsp_err_reg   <= 1'b0;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else if (cnt_reg == LAST_CNT) begin
            cyc_reg       <= 1'b0;
            rsp_dat_reg   <= '0;
            rsp_err_reg   <= 1'b1;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_dat_reg   <= '0;
            rdy_reg       <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o = rdy_reg;
  assign bus.wbm_cyc_o   = cyc_reg;
  assign bus.wbm_stb_o   = cyc_reg;
  assign bus.wbm_we_o    = we_reg;
  assign bus.wbm_adr_o   = adr_reg;
  assign bus.wbm_dat_o   = dat_reg;
  assign bus.wbm_sel_o   = sel_reg;
  assign bus.rsp_valid_o = rsp_valid_reg;
  assign bus.rsp_err_o   = rsp_err_reg;
  assign bus.rsp_dat_o   = rsp_dat_reg;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized bench for wb_cmd_master against a transaction-level outcome model.
module tb_wb_cmd_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 64;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  wb_cmd_master_if #(.AW(AW), .DW(DW)) bus ();

  wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: ack on BUS cycle k (1..TO) terminates after k cycles with data; otherwise TO cycles and error.
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int ack_at, input logic [31:0] rdata,
                        input int hold, input logic verbose_tag);
    int          exp_cyc;
    logic        exp_err;
    logic [31:0] exp_dat;
    int          k;
    logic        stable;
    logic        hold_ok;

    exp_err = !(ack_at >= 1 && ack_at <= TO);
    exp_cyc = exp_err ? TO : ack_at;
    exp_dat = (we || exp_err) ? 32'h0 : rdata;

    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    bus.cmd_sel_i   = sel;
    for (int w = 0; w < 8 && !bus.cmd_ready_o; w++) tick();
    check_val("cmd_ready_wait", 64'(bus.cmd_ready_o), 64'd1);
    tick();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_dat_i   = $urandom;
    check_val("stb_after_accept", {62'd0, bus.wbm_cyc_o, bus.wbm_stb_o}, 64'd3);
    check_val("ready_in_bus", 64'(bus.cmd_ready_o), 64'd0);
    check_val("bus_fields", {27'd0, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o},
              {27'd0, we, sel, adr});
    check_val("bus_wdata", 64'(bus.wbm_dat_o), 64'(dat));

    stable = 1'b1;
    k = 0;
    while (k < TO + 4) begin
      k++;
      bus.wbm_ack_i = (k == ack_at);
      bus.wbm_dat_i = (k == ack_at) ? rdata : 32'($urandom);
      tick();
      bus.wbm_ack_i = 1'b0;
      if (!bus.wbm_cyc_o) break;
      if (bus.wbm_adr_o !== adr || bus.wbm_dat_o !== dat || bus.wbm_sel_o !== sel ||
          bus.wbm_we_o !== we || bus.wbm_stb_o !== 1'b1) stable = 1'b0;
      if (bus.rsp_valid_o !== 1'b0) stable = 1'b0;
    end
    check_val("bus_held", 64'(stable), 64'd1);
    check_val("stb_cycles", 64'(k), 64'(exp_cyc));
    check_val("cyc_stb_dropped", {62'd0, bus.wbm_cyc_o, bus.wbm_stb_o}, 64'd0);
    check_val("rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    check_val("rsp_err", 64'(bus.rsp_err_o), 64'(exp_err));
    check_val("rsp_dat", 64'(bus.rsp_dat_o), 64'(exp_dat));

    hold_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      bus.wbm_ack_i = 1'($urandom);
      bus.wbm_dat_i = $urandom;
      tick();
      bus.wbm_ack_i = 1'b0;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== exp_err || bus.rsp_dat_o !== exp_dat ||
          bus.cmd_ready_o !== 1'b0 || bus.wbm_cyc_o !== 1'b0) hold_ok = 1'b0;
    end
    if (hold > 0) check_val("rsp_hold_stable", 64'(hold_ok), 64'd1);

    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    check_val("rsp_consumed", 64'(bus.rsp_valid_o), 64'd0);
    check_val("ready_after_rsp", 64'(bus.cmd_ready_o), 64'd1);
    if (verbose_tag)
      $display("txn we=%0d adr=%h ack_at=%0d cycles=%0d err=%0d dat=%h", we, adr, ack_at, k,
               bus.rsp_err_o, exp_dat);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          ack_at;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.cmd_sel_i   = '0;
    bus.rsp_ready_i = 1'b0;
    bus.wbm_dat_i   = '0;
    bus.wbm_ack_i   = 1'b0;

    #1;
    check_val("reset_ctrl", {59'd0, bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_err_o,
                             bus.wbm_cyc_o, bus.wbm_stb_o}, 64'd0);
    check_val("reset_bus", {27'd0, bus.wbm_we_o, bus.wbm_sel_o, bus.wbm_adr_o}, 64'd0);
    check_val("reset_dat", {bus.wbm_dat_o, bus.rsp_dat_o}, 64'd0);
    #20;
    rst_n = 1'b1;
    tick();
    check_val("ready_after_reset", 64'(bus.cmd_ready_o), 64'd1);

    // Ack while idle must not start anything.
    bus.wbm_ack_i = 1'b1;
    tick();
    bus.wbm_ack_i = 1'b0;
    check_val("idle_ack_ignored", {61'd0, bus.wbm_cyc_o, bus.rsp_valid_o, bus.cmd_ready_o}, 64'd1);

    do_txn(1'b1, 32'h2000_0000, 32'hA5A5_1234, 4'hF, 1,  32'hDEAD_BEEF, 0,  1'b1);
    do_txn(1'b0, 32'h2000_0000, 32'h0,         4'hF, 1,  32'hA5A5_1234, 0,  1'b1);
    do_txn(1'b0, 32'h3000_0000, 32'h0,         4'hF, 0,  32'h0,         0,  1'b1);
    do_txn(1'b0, 32'h3000_0004, 32'h0,         4'h3, 64, 32'h1357_9BDF, 0,  1'b1);
    do_txn(1'b0, 32'h3000_0008, 32'h0,         4'hC, 65, 32'h1111_2222, 0,  1'b1);
    do_txn(1'b0, 32'h4000_0000, 32'h0,         4'hF, 2,  32'hCAFE_F00D, 10, 1'b1);

    // Reset three cycles into BUS: outputs clear asynchronously, no response.
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b1;
    bus.cmd_adr_i   = 32'h5000_0000;
    bus.cmd_dat_i   = 32'h0BAD_F00D;
    bus.cmd_sel_i   = 4'hF;
    tick();
    bus.cmd_valid_i = 1'b0;
    check_val("rst_case_accept", 64'(bus.wbm_stb_o), 64'd1);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_bus", {61'd0, bus.wbm_cyc_o, bus.wbm_stb_o, bus.rsp_valid_o}, 64'd0);
    check_val("async_rst_ready", 64'(bus.cmd_ready_o), 64'd0);
    #3;
    rst_n = 1'b1;
    tick();
    check_val("ready_after_rst2", 64'(bus.cmd_ready_o), 64'd1);
    check_val("no_rsp_after_rst", 64'(bus.rsp_valid_o), 64'd0);
    do_txn(1'b0, 32'h5000_0000, 32'h0, 4'hF, 3, 32'h7777_8888, 0, 1'b1);

    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      d = $urandom;
      case ($urandom_range(0, 5))
        0:       ack_at = 0;
        1:       ack_at = $urandom_range(60, 70);
        default: ack_at = $urandom_range(1, 8);
      endcase
      do_txn(1'($urandom), a, d, 4'($urandom), ack_at, 32'($urandom),
             $urandom_range(0, 4), 1'b1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
